sparrow_lsu: RTL and testbench

Load/store sequencer between the sparrow decoder and the data memory port. Takes the per-instruction memory controls (request, write, access size, zero-extend) with the ALU-computed address and store operand. Runs a multi-cycle request/grant/response transaction on the data bus and stalls the core until it completes. Returns lane-aligned, sign- or zero-extended load data to the register-file write mux and flags misaligned or timed-out accesses.

---
 rtl/sparrow_lsu.sv | 157 +++++++++++++++
 tb/tb_sparrow_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sparrow_lsu.sv
// Load/store sequencer: turns decoder memory controls into a req/gnt/rvalid bus
// transaction, stalls the core meanwhile and returns lane-aligned, extended load data.
module sparrow_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        zero_extnd_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, cnt_q, cnt_inc;
  logic [3:0]  be_q, be_fmt;
  logic [31:0] wdata_fmt, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [1:0]  size_q;
  logic        we_q, zext_q, err_q;
  logic        legal, timeout_hit, abort, idle_err;

  always_comb begin
    legal     = 1'b0;
    be_fmt    = 4'b1111;
    wdata_fmt = wdata_i;
    case (size_i)
      2'b00: begin
        legal     = 1'b1;
        be_fmt    = 4'b0001 << addr_i[1:0];
        wdata_fmt = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        legal     = ~addr_i[0];
        be_fmt    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_fmt = {2{wdata_i[15:0]}};
      end
      2'b10:   legal = (addr_i[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_b = data_rdata_i[7:0];
      2'b01:   lane_b = data_rdata_i[15:8];
      2'b10:   lane_b = data_rdata_i[23:16];
      default: lane_b = data_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~zext_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~zext_q & lane_h[15]}}, lane_h};
      default: load_ext = data_rdata_i;
    endcase
  end

  assign cnt_inc     = cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_CYCLES);

  // A grant or response in the final allowed cycle still wins over the abort.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (req_i && legal) state_d = REQ;
      REQ: begin
        if (data_gnt_i) state_d = WAIT;
        else if (timeout_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      WAIT: begin
        if (data_rvalid_i) state_d = DONE;
        else if (timeout_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_i && legal) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_fmt;
            be_q    <= be_fmt;
            size_q  <= size_i;
            we_q    <= we_i;
            zext_q  <= zero_extnd_i;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (req_i) begin
            rdata_q <= '0;
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_inc;
          if (abort) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (state_q == WAIT && data_rvalid_i && !we_q) begin
            rdata_q <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

  // Misaligned requests are rejected in the same IDLE cycle, so their error is combinational.
  assign idle_err      = rst_ni & (state_q == IDLE) & req_i & ~legal;
  assign stall_o       = rst_ni & req_i & legal & (state_q != DONE);
  assign err_o         = idle_err | ((state_q == DONE) & err_q);
  assign rdata_valid_o = (state_q == DONE) & ~we_q & ~err_q;
  assign rdata_o       = idle_err ? '0 : rdata_q;
  assign data_req_o    = (state_q == REQ);
  assign data_we_o     = we_q;
  assign data_be_o     = be_q;
  assign data_addr_o   = {addr_q[31:2], 2'b00};
  assign data_wdata_o  = wdata_q;

endmodule

// File: tb/tb_sparrow_lsu.sv
// Bench for sparrow_lsu: directed scenarios plus randomized load/store traffic
// checked each cycle against a transaction-level timeline model.
module tb_sparrow_lsu;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni, req_i, we_i, zero_extnd_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rdata_valid_o, err_o, data_req_o, data_we_o;
  logic [31:0] rdata_o, data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_rdata = '0;

  sparrow_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .zero_extnd_i(zero_extnd_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .err_o(err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_of(input logic [1:0] s, input logic [31:0] a);
    return (s == 0) || (s == 1 && a % 2 == 0) || (s == 2 && a % 4 == 0);
  endfunction

  function automatic logic [31:0] be_of(input logic [1:0] s, input logic [31:0] a);
    if (s == 0) return 32'd1 << (a % 4);
    if (s == 1) return 32'd3 << (a % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] s, input logic [31:0] w);
    if (s == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (s == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] load_of(input logic [1:0] s, input logic [31:0] a,
                                          input logic z, input logic [31:0] d);
    logic [31:0] v;
    if (s == 2) return d;
    v = d >> (8 * (a % 4));
    if (s == 0) begin
      v = v & 32'hFF;
      if (!z && v >= 128) v = v - 32'd256;
    end else begin
      v = v & 32'hFFFF;
      if (!z && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the access retires.
  // g: REQ cycles without grant before the grant; r: cycles from grant to rvalid (>=1).
  task automatic run_op(input logic we, input logic [1:0] sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int unsigned g, input int unsigned r, input bit stray);
    int unsigned tg, tdone, treq_last, tmax;
    bit granted, terr;
    logic [31:0] exp_rd;
    req_i = 1'b1; we_i = we; size_i = sz; zero_extnd_i = zx; addr_i = a; wdata_i = wd;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    if (!legal_of(sz, a)) begin
      #4;
      check("mis_err", err_o, 1);
      check("mis_stall", stall_o, 0);
      check("mis_req", data_req_o, 0);
      check("mis_rdata", rdata_o, 0);
      check("mis_rvld", rdata_valid_o, 0);
      last_rdata = '0;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      return;
    end
    tg = 0;
    if (g + 1 > TO) begin
      granted = 1'b0; terr = 1'b1; treq_last = TO; tdone = TO + 1;
    end else begin
      granted = 1'b1; tg = g + 1; treq_last = tg;
      tmax = (tg + 1 > TO) ? tg + 1 : TO;
      if (tg + r <= tmax) begin terr = 1'b0; tdone = tg + r + 1; end
      else begin terr = 1'b1; tdone = tmax + 1; end
    end
    exp_rd = terr ? '0 : (we ? last_rdata : load_of(sz, a, zx, rd));
    for (int unsigned t = 0; t <= tdone; t++) begin
      data_gnt_i    = granted && t == tg;
      data_rvalid_i = granted && !terr && t == tg + r;
      if (t >= 1 && t <= treq_last && !data_gnt_i) data_rvalid_i = 1'($urandom_range(0, 1));
      data_rdata_i  = (granted && t == tg + r) ? rd : $urandom;
      #4;
      check("stall", stall_o, 32'(t < tdone));
      check("bus_req", data_req_o, 32'(t >= 1 && t <= treq_last));
      if (t >= 1 && t <= treq_last) begin
        check("bus_addr", data_addr_o, a & ~32'h3);
        check("bus_be", data_be_o, be_of(sz, a));
        check("bus_wdata", data_wdata_o, wdata_of(sz, wd));
        check("bus_we", data_we_o, we);
      end
      check("rvalid", rdata_valid_o, 32'(t == tdone && !we && !terr));
      check("err", err_o, 32'(t == tdone && terr));
      check("rdata", rdata_o, (t == tdone) ? exp_rd : last_rdata);
      @(posedge clk_i); #1;
    end
    last_rdata = exp_rd;
    req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    if (stray) idle_cycle(1'b1);
  endtask

  task automatic idle_cycle(input logic rv);
    req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = rv; data_rdata_i = $urandom;
    #4;
    check("idle_stall", stall_o, 0);
    check("idle_req", data_req_o, 0);
    check("idle_err", err_o, 0);
    check("idle_rvalid", rdata_valid_o, 0);
    check("idle_rdata", rdata_o, last_rdata);
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
  endtask

  // at_t = 1 resets while in REQ, at_t = 2 while in WAIT.
  task automatic reset_mid(input int unsigned at_t);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; zero_extnd_i = 1'b0;
    addr_i = 32'h40; wdata_i = $urandom; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    for (int unsigned t = 0; t < at_t; t++) begin
      data_gnt_i = (t == 1);
      @(posedge clk_i); #1;
    end
    data_gnt_i = 1'b0;
    #1;
    check("pre_rst_stall", stall_o, 1);
    check("pre_rst_req", data_req_o, 32'(at_t == 1));
    rst_ni = 1'b0;
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_req", data_req_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rvalid", rdata_valid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_be", data_be_o, 0);
    check("rst_addr", data_addr_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; req_i = 1'b0; last_rdata = '0;
    idle_cycle(1'b0);
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; zero_extnd_i = 1'b0;
    addr_i = 32'h100; wdata_i = 32'hFFFF_FFFF;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'hFFFF_FFFF;
    #2;
    check("reset_stall", stall_o, 0);
    check("reset_rdata", rdata_o, 0);
    check("reset_rvalid", rdata_valid_o, 0);
    check("reset_err", err_o, 0);
    check("reset_req", data_req_o, 0);
    check("reset_we", data_we_o, 0);
    check("reset_be", data_be_o, 0);
    check("reset_addr", data_addr_o, 0);
    check("reset_wdata", data_wdata_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1; req_i = 1'b0;
    idle_cycle(1'b0);

    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0);
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b0);
    run_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b0);
    run_op(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3, 1, 1'b0);
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, 1, 1'b0);
    idle_cycle(1'b0);
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h1111_2222, 0, 1, 1'b0);
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h7777_7777, 20, 1, 1'b1);
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 1, 2, 1'b0);
    reset_mid(2);
    reset_mid(1);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'h1;
        else if (sz == 2'b10) a = a & ~32'h3;
      end
      run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
             $urandom_range(0, 5), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
